// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer owning the HI/LO pair.
// Stalls HI/LO consumers and new starts while an operation runs.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             sign_q, sign_d;
  logic             rsign_q, rsign_d;
  logic             isdiv_q, isdiv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             last;
  logic [WIDTH:0]   mul_sum, mul_hi;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_rem, div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quot, rem;

  assign abs_a = srca[WIDTH-1] ? -srca : srca;
  assign abs_b = srcb[WIDTH-1] ? -srcb : srcb;
  assign last  = (cnt_q == CW'(WIDTH-1));

  // MUL: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_hi   = acc_q[0] ? mul_sum : {1'b0, acc_q[W2-1:WIDTH]};
  assign mul_next = {mul_hi, acc_q[WIDTH-1:1]};

  // DIV: acc = {remainder, quotient}, restoring step
  assign div_rem  = acc_q[W2-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_ge   = (div_rem >= {1'b0, opnd_q});
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};

  assign prod = sign_q ? -acc_q : acc_q;
  assign quot = acc_q[WIDTH-1:0];
  assign rem  = acc_q[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_mult)
          state_d = S_MUL;
        else if (start_div)
          state_d = (srcb == '0) ? S_FIN : S_DIV;
      end
      S_MUL:  if (last) state_d = S_FIN;
      S_DIV:  if (last) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = busy & (mfhi_req | mflo_req | start_mult | start_div);
  end

  always_comb begin
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    isdiv_d = isdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          opnd_d  = abs_a;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          sign_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
          isdiv_d = 1'b0;
          cnt_d   = '0;
        end else if (start_div) begin
          isdiv_d = 1'b1;
          cnt_d   = '0;
          // Divide by zero skips iteration; FINISH emits srca / all ones
          if (srcb == '0) begin
            acc_d   = {srca, {WIDTH{1'b1}}};
            sign_d  = 1'b0;
            rsign_d = 1'b0;
          end else begin
            opnd_d  = abs_b;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            sign_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
            rsign_d = srca[WIDTH-1];
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
      end
      S_FIN: begin
        if (isdiv_q) begin
          lo_d = sign_q ? -quot : quot;
          hi_d = rsign_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      isdiv_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      isdiv_q <= isdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_q == S_FIN);
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at
// issue, popped and compared by a monitor on every done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] srca, srcb;
  logic        mfhi_req, mflo_req;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int checks = 0;
  int passes = 0;
  logic [63:0] expq[$];
  logic [63:0] mon_e;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .srca(srca), .srcb(srcb),
    .mfhi_req(mfhi_req), .mflo_req(mflo_req),
    .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (expq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("hilo", {hi, lo}, mon_e);
      end
    end
  end

  task automatic wait_idle(input string nm, input int exp_busy);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({nm, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({nm, "_done_once"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_busy);
    @(negedge clk);
    start_mult = m;
    start_div  = !m;
    srca       = a;
    srcb       = b;
    expq.push_back(exp);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    wait_idle(nm, exp_busy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dn;
    logic stall_ok;
    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    mfhi_req   = 1'b0;
    mflo_req   = 1'b0;
    srca       = '0;
    srcb       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    run_op("mul_7_m3", 1'b1, 32'd7, 32'hFFFFFFFD,
           64'hFFFFFFFF_FFFFFFEB, 33);
    run_op("mul_m1_m1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'h00000000_00000001, 33);
    run_op("mul_max", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF,
           64'h3FFFFFFF_00000001, 33);
    run_op("div_100_7", 1'b0, 32'd100, 32'd7,
           64'h00000002_0000000E, 33);
    run_op("div_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 33);
    run_op("div_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 33);
    run_op("div_by0", 1'b0, 32'd5, 32'd0,
           64'h00000005_FFFFFFFF, 1);

    // MULT -1*5 with MFHI and a DIV start held from 3 cycles in
    @(negedge clk);
    start_mult = 1'b1;
    srca = 32'hFFFFFFFF;
    srcb = 32'd5;
    expq.push_back(64'hFFFFFFFF_FFFFFFFB);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (2) @(negedge clk);
    n = 2;
    @(negedge clk);
    mfhi_req  = 1'b1;
    start_div = 1'b1;
    srca = 32'd100;
    srcb = 32'd7;
    #1;
    stall_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      if (!stall) stall_ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_while_busy", 64'(stall_ok), 64'd1);
    chk("stall_busy_cycles", 64'(n), 64'd33);
    chk("stall_done_cycle", 64'(stall), 64'd0);
    chk("stall_done", 64'(done), 64'd1);
    chk("mfhi_sees_new", 64'(hi), 64'hFFFFFFFF);
    expq.push_back(64'h00000002_0000000E);
    @(posedge clk);
    #1;
    start_div = 1'b0;
    mfhi_req  = 1'b0;
    wait_idle("div_represented", 33);

    // Reset in the middle of a DIV aborts it
    @(negedge clk);
    start_div = 1'b1;
    srca = 32'd100;
    srcb = 32'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    run_op("mul_after_rst", 1'b1, 32'd7, 32'hFFFFFFFD,
           64'hFFFFFFFF_FFFFFFEB, 33);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
